// File: rtl/lsp_grid_search_ctrl.sv
// Grid-walk sequencer for the A(z)-to-LSP root search.
// Evaluates Chebps_11 at each grid point and emits sign-change interval records.
module lsp_grid_search_ctrl #(
  parameter int GRID_POINTS = 51,
  parameter int MAX_ROOTS   = 10,
  parameter int POLY_ORDER  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [5:0]  gridAddr,
  input  logic [15:0] gridData,
  output logic        chebStart,
  output logic [15:0] chebX,
  output logic [15:0] chebPolyOrder,
  input  logic        chebDone,
  input  logic [15:0] chebIn,
  output logic        intervalWe,
  output logic [3:0]  intervalAddr,
  output logic [5:0]  intervalIdx,
  output logic [3:0]  rootCount,
  output logic        done
);

  localparam logic [5:0] LAST_J = 6'(GRID_POINTS - 1);
  localparam logic [3:0] MAX_RC = 4'(MAX_ROOTS);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    CHECK,
    NEXT,
    DONE
  } state_t;

  state_t      state_q;
  logic [5:0]  j_q;
  logic [15:0] ylow_q;
  logic [15:0] yhigh_q;
  logic        first_q;
  logic [15:0] x_q;
  logic        cs_q;
  logic        we_q;
  logic [3:0]  waddr_q;
  logic [5:0]  widx_q;
  logic [3:0]  rc_q;
  logic        done_q;

  logic        root_d;
  logic [3:0]  rc_d;
  logic [5:0]  j_d;

  // Sign test equivalent to L_mult(yLow, yHigh) <= 0.
  always_comb begin
    root_d = (ylow_q == 16'd0) || (yhigh_q == 16'd0) ||
             (ylow_q[15] != yhigh_q[15]);
    rc_d   = rc_q + 4'd1;
    j_d    = j_q + 6'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      j_q     <= '0;
      ylow_q  <= '0;
      yhigh_q <= '0;
      first_q <= 1'b0;
      x_q     <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      widx_q  <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            j_q     <= '0;
            rc_q    <= '0;
            done_q  <= 1'b0;
            first_q <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          x_q     <= gridData;
          cs_q    <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          cs_q    <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (chebDone) begin
            yhigh_q <= chebIn;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!first_q && root_d) begin
            we_q    <= 1'b1;
            waddr_q <= rc_q;
            widx_q  <= j_q;
            rc_q    <= rc_d;
          end
          ylow_q  <= yhigh_q;
          first_q <= 1'b0;
          state_q <= NEXT;
        end
        NEXT: begin
          we_q <= 1'b0;
          if (rc_q == MAX_RC || j_q == LAST_J) begin
            state_q <= DONE;
          end else begin
            j_q     <= j_d;
            state_q <= FETCH;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gridAddr      = j_q;
  assign chebStart     = cs_q;
  assign chebX         = x_q;
  assign chebPolyOrder = 16'(POLY_ORDER);
  assign intervalWe    = we_q;
  assign intervalAddr  = waddr_q;
  assign intervalIdx   = widx_q;
  assign rootCount     = rc_q;
  assign done          = done_q;

endmodule

// File: tb/tb_lsp_grid_search_ctrl.sv
// Directed bench for lsp_grid_search_ctrl.
// Behavioural Chebps_11 model with fixed latency and scenario-selected values.
module tb_lsp_grid_search_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  gridAddr;
  logic [15:0] gridData;
  logic        chebStart;
  logic [15:0] chebX;
  logic [15:0] chebPolyOrder;
  logic        chebDone;
  logic [15:0] chebIn;
  logic        intervalWe;
  logic [3:0]  intervalAddr;
  logic [5:0]  intervalIdx;
  logic [3:0]  rootCount;
  logic        done;

  int checks = 0;
  int fails  = 0;
  int mode   = 0;

  lsp_grid_search_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .gridAddr(gridAddr), .gridData(gridData),
    .chebStart(chebStart), .chebX(chebX),
    .chebPolyOrder(chebPolyOrder),
    .chebDone(chebDone), .chebIn(chebIn),
    .intervalWe(intervalWe), .intervalAddr(intervalAddr),
    .intervalIdx(intervalIdx), .rootCount(rootCount),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [5:0] a);
    return 16'({10'd0, a} * 600 + 3);
  endfunction

  function automatic logic [15:0] model_val(input int m, input int j);
    case (m)
      1: return (j < 3) ? 16'sd100 : (j < 7) ? -16'sd50 : 16'sd20;
      2: return (j == 5) ? 16'd0 : 16'd1;
      3: return (j % 2 == 1) ? -16'sd1 : 16'sd1;
      default: return 16'sd100;
    endcase
  endfunction

  assign gridData = rom(gridAddr);

  // Chebps_11 model: clears done on start, answers after a fixed delay.
  logic       busy;
  int         cnt;
  logic [5:0] cur_idx;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      cnt      <= 0;
      cur_idx  <= '0;
      chebDone <= 1'b0;
      chebIn   <= '0;
    end else if (chebStart) begin
      busy     <= 1'b1;
      cnt      <= 2;
      cur_idx  <= gridAddr;
      chebDone <= 1'b0;
    end else if (busy) begin
      if (cnt == 0) begin
        busy     <= 1'b0;
        chebDone <= 1'b1;
        chebIn   <= model_val(mode, int'(cur_idx));
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  int         starts = 0;
  int         iws    = 0;
  logic [5:0] addr_log [1024];
  logic [15:0] x_log   [1024];
  logic [5:0] iw_idx   [1024];
  logic [3:0] iw_addr  [1024];
  always @(posedge clk) begin
    if (chebStart) begin
      addr_log[starts] <= gridAddr;
      x_log[starts]    <= chebX;
      starts           <= starts + 1;
    end
    if (intervalWe) begin
      iw_idx[iws]  <= intervalIdx;
      iw_addr[iws] <= intervalAddr;
      iws          <= iws + 1;
    end
  end

  task automatic run_search(input bit inject);
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      start = (inject && (n == 40 || n == 200 || n == 201));
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL search_timeout: done=%b after %0d cycles, want 1", done, n);
    end
  endtask

  task automatic check_full_walk(input int s0, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 51; i++)
      if (addr_log[s0 + i] !== 6'(i)) bad++;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s_gridaddr_seq: %0d wrong addresses, want 0", tag, bad);
    end
    bad = 0;
    for (int i = 0; i < 51; i++)
      if (x_log[s0 + i] !== rom(6'(i))) bad++;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s_chebx_seq: %0d wrong operands, want 0", tag, bad);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({gridAddr, chebX, intervalAddr, intervalIdx, rootCount,
         chebStart, intervalWe, done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ga=%0d x=%0d ia=%0d ii=%0d rc=%0d cs=%b we=%b d=%b want all 0",
               gridAddr, chebX, intervalAddr, intervalIdx, rootCount,
               chebStart, intervalWe, done);
    end
    checks++;
    if (chebPolyOrder !== 16'd5) begin
      fails++;
      $display("FAIL reset_polyorder: got %0d want 5", chebPolyOrder);
    end
  endtask

  task automatic test_no_roots();
    int s0, i0;
    mode = 0;
    s0 = starts; i0 = iws;
    run_search(1'b0);
    checks++;
    if (starts - s0 != 51) begin
      fails++;
      $display("FAIL noroot_starts: got %0d want 51", starts - s0);
    end
    checks++;
    if (iws - i0 != 0) begin
      fails++;
      $display("FAIL noroot_we: got %0d want 0", iws - i0);
    end
    checks++;
    if (rootCount !== 4'd0) begin
      fails++;
      $display("FAIL noroot_rc: got %0d want 0", rootCount);
    end
    check_full_walk(s0, "noroot");
  endtask

  task automatic check_two(input int i0, input int a, input int b, input string tag);
    checks++;
    if (iws - i0 != 2) begin
      fails++;
      $display("FAIL %s_we_count: got %0d want 2", tag, iws - i0);
    end else begin
      checks++;
      if (iw_idx[i0] !== 6'(a) || iw_idx[i0 + 1] !== 6'(b)) begin
        fails++;
        $display("FAIL %s_idx: got %0d,%0d want %0d,%0d",
                 tag, iw_idx[i0], iw_idx[i0 + 1], a, b);
      end
      checks++;
      if (iw_addr[i0] !== 4'd0 || iw_addr[i0 + 1] !== 4'd1) begin
        fails++;
        $display("FAIL %s_addr: got %0d,%0d want 0,1",
                 tag, iw_addr[i0], iw_addr[i0 + 1]);
      end
    end
    checks++;
    if (rootCount !== 4'd2) begin
      fails++;
      $display("FAIL %s_rc: got %0d want 2", tag, rootCount);
    end
  endtask

  task automatic test_two_roots();
    int i0;
    mode = 1;
    i0 = iws;
    run_search(1'b0);
    check_two(i0, 3, 7, "tworoot");
  endtask

  task automatic test_zero_value();
    int i0;
    mode = 2;
    i0 = iws;
    run_search(1'b0);
    check_two(i0, 5, 6, "zero");
  endtask

  task automatic test_saturate();
    int s0, i0, bad;
    mode = 3;
    s0 = starts; i0 = iws;
    run_search(1'b0);
    checks++;
    if (iws - i0 != 10) begin
      fails++;
      $display("FAIL sat_we_count: got %0d want 10", iws - i0);
    end
    bad = 0;
    for (int k = 0; k < 10; k++)
      if (iw_idx[i0 + k] !== 6'(k + 1) || iw_addr[i0 + k] !== 4'(k)) bad++;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL sat_records: %0d wrong records, want 0", bad);
    end
    checks++;
    if (starts - s0 != 11) begin
      fails++;
      $display("FAIL sat_starts: got %0d want 11", starts - s0);
    end
    checks++;
    if (rootCount !== 4'd10) begin
      fails++;
      $display("FAIL sat_rc: got %0d want 10", rootCount);
    end
  endtask

  task automatic test_abort();
    int n, s0, i0;
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(chebStart && gridAddr == 6'd20) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(chebStart && gridAddr == 6'd20)) begin
      fails++;
      $display("FAIL abort_reach_j20: gridAddr=%0d, want issue at 20", gridAddr);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({gridAddr, chebX, intervalAddr, intervalIdx, rootCount,
         chebStart, intervalWe, done} !== '0) begin
      fails++;
      $display("FAIL abort_outputs: ga=%0d x=%0d ia=%0d ii=%0d rc=%0d cs=%b we=%b d=%b want all 0",
               gridAddr, chebX, intervalAddr, intervalIdx, rootCount,
               chebStart, intervalWe, done);
    end
    @(negedge clk);
    reset = 1'b0;
    s0 = starts; i0 = iws;
    repeat (10) @(negedge clk);
    checks++;
    if (starts != s0 || iws != i0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: starts=%0d we=%0d done=%b want 0,0,0",
               starts - s0, iws - i0, done);
    end
    s0 = starts;
    run_search(1'b0);
    checks++;
    if (starts - s0 != 51) begin
      fails++;
      $display("FAIL abort_rerun_starts: got %0d want 51", starts - s0);
    end
    check_full_walk(s0, "rerun");
  endtask

  task automatic test_back_to_back();
    int s0, i0;
    mode = 1;
    s0 = starts; i0 = iws;
    run_search(1'b1);
    checks++;
    if (starts - s0 != 51) begin
      fails++;
      $display("FAIL b2b_first_starts: got %0d want 51", starts - s0);
    end
    check_two(i0, 3, 7, "b2b_first");
    s0 = starts; i0 = iws;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (rootCount !== 4'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_restart: rc=%0d done=%b want 0,0", rootCount, done);
    end
    while (!done && starts - s0 < 60) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second_timeout: done=%b want 1", done);
    end
    checks++;
    if (starts - s0 != 51) begin
      fails++;
      $display("FAIL b2b_second_starts: got %0d want 51", starts - s0);
    end
    check_two(i0, 3, 7, "b2b_second");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_no_roots();
    test_two_roots();
    test_zero_value();
    test_saturate();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/lsp_grid_search_ctrl.md
Name: lsp_grid_search_ctrl

Overview:
- Sequencer for the A(z)-to-LSP root search.
- Walks the 51-point cosine grid table and issues one Chebps_11 evaluation per grid point through the Chebps start/done handshake.
- Detects sign changes between consecutive polynomial values and reports each bracketing interval to the downstream bisection/interpolation stage.
- Sits between the grid ROM and the Chebps_11 FSM.

Parameters:
- GRID_POINTS, 51, number of grid entries evaluated (indices 0..GRID_POINTS-1).
- MAX_ROOTS, 10, number of intervals after which the search stops (LPC order M).
- POLY_ORDER, 5, constant driven on chebPolyOrder.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a search; sampled only in IDLE
- gridAddr  out  6  grid ROM address
- gridData  in  16  grid ROM word, combinational from gridAddr (Q15 cosine)
- chebStart  out  1  one-cycle start pulse to Chebps_11
- chebX  out  16  x operand to Chebps_11, held stable from chebStart until chebDone
- chebPolyOrder  out  16  constant POLY_ORDER
- chebDone  in  1  Chebps_11 result valid
- chebIn  in  16  Chebps_11 result (signed Q-format)
- intervalWe  out  1  one-cycle write strobe for one interval record
- intervalAddr  out  4  record slot, equal to rootCount before increment
- intervalIdx  out  6  grid index j; the root lies in [grid[j-1], grid[j]]
- rootCount  out  4  intervals found in the current search
- done  out  1  search complete

Behaviour:
- Reset (asynchronous): all registers cleared.
  - state=IDLE.
  - gridAddr, chebX, intervalAddr, intervalIdx, rootCount = 0.
  - chebStart, intervalWe, done = 0.
  - chebPolyOrder is constant.
- Reset asserted mid-search aborts immediately. No intervalWe is issued afterwards. The controller does not wait for Chebps.
- Registers: j (6b grid index), yLow (16b previous value), first (1b).
- States:
  - IDLE: done held from the previous search. On start=1: j=0, gridAddr=0, rootCount=0, done=0, first=1 -> FETCH.
  - FETCH: chebX <= gridData -> ISSUE.
  - ISSUE: chebStart=1 for exactly this cycle -> WAIT.
  - WAIT: hold chebX. On chebDone=1, latch yHigh=chebIn -> CHECK.
  - CHECK (one cycle):
    - If first=0 and the values bracket a root, pulse intervalWe with intervalIdx=j and intervalAddr=rootCount, and increment rootCount.
    - A root is bracketed when yLow==0, or yHigh==0, or yLow[15]!=yHigh[15]. This is the G.729 L_mult(yLow,yHigh)<=0 test without the multiply.
    - Then: yLow<=yHigh, first<=0 -> NEXT.
  - NEXT:
    - If rootCount==MAX_ROOTS or j==GRID_POINTS-1 -> DONE.
    - Else j++, gridAddr=j+1 -> FETCH.
  - DONE: done=1 -> IDLE. done stays high until the next accepted start.
- Latency per grid point: 5 cycles plus the Chebps_11 evaluation time. A full search issues GRID_POINTS chebStart pulses when fewer than MAX_ROOTS roots exist.
- start outside IDLE is ignored. A start held high continuously re-triggers a new search on the cycle after DONE.
- Chebps_11 contract: it clears done on chebStart, so the chebDone sampled in WAIT always belongs to the current evaluation.
- chebDone outside WAIT is ignored.
- A zero value at point j and again at j+1 counts as two intervals (matches the reference C, no deduplication).
- rootCount saturates at MAX_ROOTS because the search stops there. No further intervalWe is issued.
- The interval record store is external. This block only produces write strobes.

Test Plan:
1. Bench Chebps model returns +100 for all 51 points -> 51 chebStart pulses, no intervalWe, rootCount=0, done=1; gridAddr sequence 0..50 verified.
2. Model returns +100 for j<3, -50 for 3<=j<7, +20 for j>=7 -> intervalWe twice, intervalIdx=3 then 7, intervalAddr=0 then 1, rootCount=2.
3. Model returns y[5]=0, otherwise +1 -> intervals at j=5 and j=6, rootCount=2.
4. Model alternates sign every point -> exactly 10 intervalWe (j=1..10), done after the 11th evaluation, chebStart count=11.
5. Reset pulsed while in WAIT at j=20 -> all outputs 0 within the same cycle, state IDLE. A new start runs a full clean search from j=0.
6. Two back-to-back searches, with start re-pulsed after done and start pulses injected mid-search -> mid-search starts ignored; second search begins with rootCount=0 and reproduces the scenario-2 results.
